// File: rtl/voxel_ram_responder.sv
// Voxel world BRAM with a read-request FSM and an independent write port.
// Define VOXEL_RAM_OOB_FILL_EN to answer out-of-bounds reads with OOB_BLOCK.
module voxel_ram_responder #(
  parameter int LOG_X        = 5,
  parameter int LOG_Y        = 5,
  parameter int LOG_Z        = 5,
  parameter int READ_LATENCY = 2,
  parameter int COORD_W      = 16,
  parameter int BLOCK_W      = 8,
  parameter logic [BLOCK_W-1:0] BLOCK_AIR = '0,
  parameter logic [BLOCK_W-1:0] OOB_BLOCK = BLOCK_AIR
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [3*COORD_W-1:0]   ram_addr,
  input  logic                   ram_read_enable,
  output logic [BLOCK_W-1:0]     ram_out,
  output logic                   ram_valid,
  input  logic                   wr_en,
  input  logic [3*COORD_W-1:0]   wr_addr,
  input  logic [BLOCK_W-1:0]     wr_data,
  output logic                   busy
);

  localparam int IW    = LOG_X + LOG_Y + LOG_Z;
  localparam int DEPTH = 1 << IW;
  localparam int CW    = (READ_LATENCY > 2) ?
                         $clog2(READ_LATENCY - 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(READ_LATENCY - 2);

`ifdef VOXEL_RAM_OOB_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_GAP
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0]      cnt;
  logic [IW-1:0]      idx_q;
  logic               oob_q;
  logic [BLOCK_W-1:0] mem [DEPTH];
  logic [BLOCK_W-1:0] rd_pipe [READ_LATENCY];

  // Positions pack as {x, y, z}, each a signed COORD_W field.
  // Negative values set the sign bit, so one OR covers both bounds.
  function automatic logic oob_of(input logic [3*COORD_W-1:0] p);
    return (|p[3*COORD_W-1:2*COORD_W+LOG_X]) |
           (|p[2*COORD_W-1:COORD_W+LOG_Y]) |
           (|p[COORD_W-1:LOG_Z]);
  endfunction

  function automatic logic [IW-1:0] idx_of(
    input logic [3*COORD_W-1:0] p);
    return {p[COORD_W+LOG_Y-1:COORD_W],
            p[LOG_Z-1:0],
            p[2*COORD_W+LOG_X-1:2*COORD_W]};
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx_q <= '0;
      oob_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (state == S_WAIT && state_nx == S_WAIT) ?
               cnt + 1'b1 : '0;
      if (state == S_IDLE && ram_read_enable) begin
        idx_q <= idx_of(ram_addr);
        oob_q <= oob_of(ram_addr);
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (ram_read_enable) state_nx = S_ISSUE;
      S_ISSUE:
        if (!ram_read_enable)       state_nx = S_IDLE;
        else if (READ_LATENCY == 1) state_nx = S_RESP;
        else                        state_nx = S_WAIT;
      S_WAIT:
        if (!ram_read_enable)  state_nx = S_IDLE;
        else if (cnt == LAST)  state_nx = S_RESP;
      S_RESP:  state_nx = S_GAP;
      S_GAP:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ram_valid = (state == S_RESP);
    busy      = (state != S_IDLE);
    ram_out   = BLOCK_AIR;
    if (ram_valid)
      ram_out = (FILL && oob_q) ? OOB_BLOCK :
                rd_pipe[READ_LATENCY-1];
  end

  // Writes ignore reset so the world can be loaded at any time.
  always_ff @(posedge clk_in) begin
    if (wr_en && !oob_of(wr_addr))
      mem[idx_of(wr_addr)] <= wr_data;
  end

  // Read-first: the sample at the end of ISSUE sees pre-write data.
  always_ff @(posedge clk_in) begin
    rd_pipe[0] <= mem[idx_q];
    for (int i = 1; i < READ_LATENCY; i++)
      rd_pipe[i] <= rd_pipe[i-1];
  end

endmodule

// File: doc/voxel_ram_responder.md
Name: voxel_ram_responder

Overview:
Responder end of the voxel memory read interface used by the traversal unit. It accepts a block-position read request and looks the voxel up in an on-chip world BRAM. It returns the BlockType with a one-cycle valid pulse. A separate single-cycle write port loads and edits the world. It sits between the ray traversal units' memory interface and the world storage.

Parameters:
LOG_X, 5, log2 of world size along x (world spans x in [0, 2^LOG_X))
LOG_Y, 5, log2 of world size along y
LOG_Z, 5, log2 of world size along z
READ_LATENCY, 2, BRAM read latency in cycles (address to data), minimum 1
OOB_BLOCK, BLOCK_AIR, BlockType returned for out-of-bounds reads (used only when the optional feature is compiled in)

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous reset, active-high
ram_addr  input  BlockPos  requested voxel (signed x,y,z)
ram_read_enable  input  1  request is asserted while high; held by the requester
ram_out  output  BlockType  voxel contents; meaningful only when ram_valid is high
ram_valid  output  1  one-cycle pulse: ram_out holds the answer for the address latched at accept
wr_en  input  1  world write strobe
wr_addr  input  BlockPos  write position
wr_data  input  BlockType  block written
busy  output  1  high from accept through the GAP state

Behaviour:
- One clock, clk_in. rst_in is synchronous and active-high.
- Reset values: ram_valid=0, ram_out=BLOCK_AIR, busy=0, state=IDLE, latency counter=0, latched address/oob flag=0. BRAM contents are not cleared by reset.
- States:
  - IDLE: if ram_read_enable=1, accept (latch ram_addr and compute oob) -> ISSUE; else stay.
  - ISSUE: present the linear index to the BRAM read port -> WAIT.
  - WAIT: count READ_LATENCY-1 further cycles -> RESP.
  - RESP: drive ram_out=BRAM data and ram_valid=1 for exactly this cycle -> GAP.
  - GAP: ram_valid=0; -> IDLE unconditionally.
- GAP exists because the requester updates its address on the edge where it sees ram_valid. The next accept therefore samples the new address and never the stale one.
- Timing: accept at cycle 0, ram_valid at cycle READ_LATENCY+1, next possible accept at cycle READ_LATENCY+3.
- Bounds check: oob=1 if any coordinate is negative or any coordinate is >= 2^LOG_axis. The check is signed and uses the full BlockPos width.
- Linear index = {y[LOG_Y-1:0], z[LOG_Z-1:0], x[LOG_X-1:0]}. BRAM depth = 2^(LOG_X+LOG_Y+LOG_Z).
- Abort: if ram_read_enable falls while in ISSUE or WAIT, the block returns to IDLE on the next edge and emits no ram_valid. A drop during RESP does not cancel that cycle's pulse.
- Write port: true dual-port BRAM; the write port is independent of the read FSM.
  - wr_en with in-bounds wr_addr writes in 1 cycle.
  - Out-of-bounds writes are silently dropped.
  - Writes are accepted in any state, including during reset.
- Same-address collision: a read in flight while the same index is written returns the old value (read-first). Reads accepted after the write edge see the new value.
- Reset mid-operation: the FSM returns to IDLE and any in-flight response is discarded (no ram_valid).

Optional Feature:
VOXEL_RAM_OOB_FILL_EN:
- Defined: oob reads skip the BRAM and return OOB_BLOCK with the same timing, ram_valid at cycle READ_LATENCY+1.
- Undefined: oob reads still go through the BRAM using the truncated index (aliasing). The requester must bound its own traversal.

Test Plan:
- Write BLOCK id 3 at (1,2,3), then hold read_enable with ram_addr=(1,2,3) -> ram_valid pulses once at accept+3 (READ_LATENCY=2) with ram_out=3.
- Hold read_enable and change ram_addr on the cycle after each ram_valid through (0,0,0),(1,0,0),(2,0,0), pre-written 0,5,7 -> valid pulses exactly 5 cycles apart carrying 0,5,7 in order, with no stale repeats.
- Drop read_enable 1 cycle after accept -> no ram_valid; the next request is accepted normally from IDLE.
- Read (-1,0,0) and (32,0,0) with feature on and OOB_BLOCK=9 -> ram_out=9. With feature off -> no hang, valid still pulses at accept+3.
- In-flight read of (4,4,4) (old=1) while writing 6 to (4,4,4) in the ISSUE cycle -> returns 1; the next read returns 6.
- Assert rst_in during WAIT -> ram_valid stays 0, busy=0 the next cycle; BRAM data written before the reset is still readable afterwards.
